// File: rtl/calc_addsub_seq.sv
// Digit-serial two's-complement add/subtract unit with accumulator, CHUNK bits per cycle.
// Valid/ready on both sides; flags and accumulator update on entry to DONE.
module calc_addsub_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    input  logic             flag_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             ovf_sticky,
    output logic [WIDTH-1:0] acc
);

    localparam int NSTEP = WIDTH / CHUNK;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_left;
    logic [WIDTH-1:0] r_right;
    logic [WIDTH-1:0] r_sum;
    logic [SW-1:0]    r_step;
    logic             r_carry;
    logic             r_acc_op;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_zero;
    logic             r_negative;
    logic             r_sticky;
    logic [WIDTH-1:0] r_acc;

    logic [CHUNK:0]   w_c;
    logic [CHUNK-1:0] w_chunk_sum;
    logic [WIDTH-1:0] w_full_sum;
    logic [WIDTH-1:0] w_rhs;
    logic             w_last;
    logic             w_finish;
    logic             w_ovf;

    // Ripple chain over one chunk; operands shift right so the active chunk is always the low bits.
    assign w_c[0] = r_carry;
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
        assign w_chunk_sum[gi] = r_left[gi] ^ r_right[gi] ^ w_c[gi];
        assign w_c[gi+1]       = (r_left[gi] & r_right[gi]) | (w_c[gi] & (r_left[gi] ^ r_right[gi]));
    end

    assign w_full_sum = (r_sum >> CHUNK) | (WIDTH'(w_chunk_sum) << (WIDTH - CHUNK));
    assign w_last     = (r_step == SW'(NSTEP - 1));
    assign w_finish   = (r_state == S_RUN) && w_last;
    // On the final step the chunk's top carries are the carries into and out of the MSB.
    assign w_ovf      = w_c[CHUNK] ^ w_c[CHUNK-1];
    assign w_rhs      = op[1] ? a : b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_left      <= '0;
            r_right     <= '0;
            r_sum       <= '0;
            r_step      <= '0;
            r_carry     <= 1'b0;
            r_acc_op    <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_sticky    <= 1'b0;
            r_acc       <= '0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_left   <= op[1] ? r_acc : a;
                r_right  <= op[0] ? ~w_rhs : w_rhs;
                r_carry  <= op[0];
                r_acc_op <= op[1];
                r_step   <= '0;
                r_sum    <= '0;
            end
            if (r_state == S_RUN) begin
                r_left  <= r_left >> CHUNK;
                r_right <= r_right >> CHUNK;
                r_sum   <= w_full_sum;
                r_carry <= w_c[CHUNK];
                r_step  <= r_step + 1'b1;
            end
            if (w_finish) begin
                r_result    <= w_full_sum;
                r_carry_out <= w_c[CHUNK];
                r_overflow  <= w_ovf;
                r_zero      <= (w_full_sum == '0);
                r_negative  <= w_full_sum[WIDTH-1];
            end
            if (acc_clr) begin
                r_acc <= '0;
            end else if (w_finish && r_acc_op) begin
                r_acc <= w_full_sum;
            end
            if (w_finish && w_ovf) begin
                r_sticky <= 1'b1;
            end else if (flag_clr) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign result     = r_result;
    assign carry_out  = r_carry_out;
    assign overflow   = r_overflow;
    assign zero       = r_zero;
    assign negative   = r_negative;
    assign ovf_sticky = r_sticky;
    assign acc        = r_acc;

endmodule

// File: tb/tb_calc_addsub_seq.sv
// Scoreboard bench: three instances (CHUNK 4, 8, 1) at WIDTH 8; driver pushes expected
// responses, per-instance monitors pop and compare on each output handshake.
module tb_calc_addsub_seq;

    localparam int ND = 3;

    typedef struct {
        int         dut;
        logic [7:0] res;
        logic [3:0] fl;   // {carry_out, overflow, zero, negative}
        logic       st;
        logic [7:0] acc;
        int         acc_cyc;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       acc_clr;
    logic       flag_clr;
    logic       out_ready;
    logic       in_valid_s [ND];
    logic [1:0] op_s       [ND];
    logic [7:0] a_s        [ND];
    logic [7:0] b_s        [ND];
    logic       in_ready_s [ND];
    logic       out_valid_s[ND];
    logic [7:0] res_s      [ND];
    logic       co_s       [ND];
    logic       ov_s       [ND];
    logic       z_s        [ND];
    logic       n_s        [ND];
    logic       st_s       [ND];
    logic [7:0] acc_s      [ND];

    exp_t sb[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s dut=%0d actual=%0h required=%0h", nm, d, act, req);
    endtask

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        localparam int CH = (gi == 0) ? 4 : ((gi == 1) ? 8 : 1);
        int   rise_cyc = 0;
        bit   seen = 0;
        exp_t e;

        calc_addsub_seq #(.WIDTH(8), .CHUNK(CH)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid_s[gi]),
            .in_ready  (in_ready_s[gi]),
            .op        (op_s[gi]),
            .a         (a_s[gi]),
            .b         (b_s[gi]),
            .acc_clr   (acc_clr),
            .flag_clr  (flag_clr),
            .out_valid (out_valid_s[gi]),
            .out_ready (out_ready),
            .result    (res_s[gi]),
            .carry_out (co_s[gi]),
            .overflow  (ov_s[gi]),
            .zero      (z_s[gi]),
            .negative  (n_s[gi]),
            .ovf_sticky(st_s[gi]),
            .acc       (acc_s[gi])
        );

        always @(negedge clk) begin
            if (out_valid_s[gi]) begin
                if (!seen) begin
                    seen     = 1;
                    rise_cyc = cyc;
                end
                if (out_ready) begin
                    seen = 0;
                    chk("expected_output", gi,
                        int'(sb.size() != 0 && sb[0].dut == gi), 1);
                    if (sb.size() != 0 && sb[0].dut == gi) begin
                        e = sb.pop_front();
                        chk("result", gi, int'(res_s[gi]), int'(e.res));
                        chk("flags_cvzn", gi, int'({co_s[gi], ov_s[gi], z_s[gi], n_s[gi]}), int'(e.fl));
                        chk("ovf_sticky", gi, int'(st_s[gi]), int'(e.st));
                        chk("acc", gi, int'(acc_s[gi]), int'(e.acc));
                        chk("latency", gi, rise_cyc - e.acc_cyc, e.lat);
                    end
                end
            end
        end
    end

    task automatic do_op(input int d, input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] er, input logic [3:0] efl, input logic es,
                         input logic [7:0] eacc, input int elat, input bit wait_done, input bit clr_run);
        exp_t x;
        int   k;
        k = 0;
        @(negedge clk);
        while (!in_ready_s[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_before_issue", d, int'(in_ready_s[d]), 1);
        in_valid_s[d] = 1'b1;
        op_s[d] = o;
        a_s[d]  = av;
        b_s[d]  = bv;
        @(posedge clk);
        #1;
        x.dut = d; x.res = er; x.fl = efl; x.st = es; x.acc = eacc; x.acc_cyc = cyc; x.lat = elat;
        sb.push_back(x);
        in_valid_s[d] = 1'b0;
        if (clr_run) begin
            acc_clr = 1'b1;
            @(posedge clk);
            #1;
            acc_clr = 1'b0;
        end
        if (wait_done) begin
            k = 0;
            while (sb.size() != 0 && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("drained", d, sb.size(), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog dut=0 actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset = 1'b1; acc_clr = 1'b0; flag_clr = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < ND; i++) begin
            in_valid_s[i] = 1'b0; op_s[i] = 2'b00; a_s[i] = 8'h00; b_s[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 0, int'(in_ready_s[0]), 1);
        chk("reset_out_valid", 0, int'(out_valid_s[0]), 0);
        chk("reset_result", 0, int'(res_s[0]), 0);
        chk("reset_flags", 0, int'({co_s[0], ov_s[0], z_s[0], n_s[0]}), 0);
        chk("reset_acc", 0, int'(acc_s[0]), 0);
        chk("reset_sticky", 0, int'(st_s[0]), 0);

        // ADD / SUB with overflow and borrow cases
        do_op(0, 2'b00, 8'h7F, 8'h01, 8'h80, 4'b0101, 1'b1, 8'h00, 2, 1, 0);
        do_op(0, 2'b01, 8'h05, 8'h07, 8'hFE, 4'b0001, 1'b1, 8'h00, 2, 1, 0);
        do_op(0, 2'b01, 8'h80, 8'h01, 8'h7F, 4'b1100, 1'b1, 8'h00, 2, 1, 0);

        @(negedge clk); flag_clr = 1'b1;
        @(posedge clk); #1 flag_clr = 1'b0;
        @(negedge clk);
        chk("flag_clr_sticky", 0, int'(st_s[0]), 0);

        // Accumulator chain
        do_op(0, 2'b10, 8'h10, 8'hAA, 8'h10, 4'b0000, 1'b0, 8'h10, 2, 1, 0);
        do_op(0, 2'b10, 8'h10, 8'hAA, 8'h20, 4'b0000, 1'b0, 8'h20, 2, 1, 0);
        do_op(0, 2'b10, 8'h10, 8'hAA, 8'h30, 4'b0000, 1'b0, 8'h30, 2, 1, 0);
        do_op(0, 2'b11, 8'h30, 8'h55, 8'h00, 4'b1010, 1'b0, 8'h00, 2, 1, 0);
        do_op(0, 2'b00, 8'h01, 8'h01, 8'h02, 4'b0000, 1'b0, 8'h00, 2, 1, 0);

        // Backpressure: result held in DONE, new request ignored
        out_ready = 1'b0;
        do_op(0, 2'b00, 8'h40, 8'h40, 8'h80, 4'b0101, 1'b1, 8'h00, 2, 0, 0);
        k = 0;
        while (!out_valid_s[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        in_valid_s[0] = 1'b1; op_s[0] = 2'b00; a_s[0] = 8'h01; b_s[0] = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 0, int'(out_valid_s[0]), 1);
            chk("bp_result", 0, int'(res_s[0]), 'h80);
            chk("bp_in_ready", 0, int'(in_ready_s[0]), 0);
        end
        in_valid_s[0] = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", 0, int'(in_ready_s[0]), 1);
        chk("bp_drained", 0, sb.size(), 0);
        repeat (4) @(negedge clk);

        // Abort in RUN via reset
        do_op(0, 2'b10, 8'h10, 8'h00, 8'h10, 4'b0000, 1'b1, 8'h10, 2, 1, 0);
        @(negedge clk);
        in_valid_s[0] = 1'b1; op_s[0] = 2'b10; a_s[0] = 8'h22;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_out_valid", 0, int'(out_valid_s[0]), 0);
        end
        chk("abort_acc", 0, int'(acc_s[0]), 0);
        chk("abort_sticky", 0, int'(st_s[0]), 0);
        chk("abort_in_ready", 0, int'(in_ready_s[0]), 1);

        // acc_clr during RUN does not disturb the in-flight operand; clear in IDLE does
        do_op(0, 2'b10, 8'h10, 8'h00, 8'h10, 4'b0000, 1'b0, 8'h10, 2, 1, 0);
        do_op(0, 2'b10, 8'h05, 8'h00, 8'h15, 4'b0000, 1'b0, 8'h15, 2, 1, 1);
        @(negedge clk); acc_clr = 1'b1;
        @(posedge clk); #1 acc_clr = 1'b0;
        @(negedge clk);
        chk("acc_clr_idle", 0, int'(acc_s[0]), 0);

        // Chunk-size extremes
        do_op(1, 2'b00, 8'hFF, 8'h01, 8'h00, 4'b1010, 1'b0, 8'h00, 1, 1, 0);
        do_op(2, 2'b00, 8'hFF, 8'h01, 8'h00, 4'b1010, 1'b0, 8'h00, 8, 1, 0);
        do_op(2, 2'b01, 8'h80, 8'h01, 8'h7F, 4'b1100, 1'b1, 8'h00, 8, 1, 0);

        repeat (4) @(negedge clk);
        chk("final_queue_empty", 0, sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
